// File: rtl/buff_pkg.sv
// Shared definitions for the circular buffer and its sharing controller.
package buff_pkg;

  localparam int NUMELEM_DEF = 4;
  localparam int BITDATA_DEF = 4;

  // Index width for a buffer of n elements; never narrower than one bit.
  function automatic int bitelem(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Occupancy count at the default depth (0..NUMELEM_DEF inclusive).
  typedef logic [bitelem(NUMELEM_DEF):0] cnt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr when enabled.
module rr_arbiter #(
  parameter int NUMREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUMREQ-1:0] req,
  input  logic              en,
  output logic [NUMREQ-1:0] gnt
);
  import buff_pkg::*;

  localparam int PW = bitelem(NUMREQ);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt_idx;
  logic          found;
  int            idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUMREQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUMREQ;
      if (!found && en && !rst && req[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_idx     = PW'(idx);
      end
    end
  end

  // Winner drops to lowest priority so every holder is served within NUMREQ grants.
  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (found)
      rr_ptr <= (gnt_idx == PW'(NUMREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/buff_share_ctrl.sv
// Shares one FIFO push port among NUMREQ producers; shadow count guards push/pop.
module buff_share_ctrl
  import buff_pkg::*;
#(
  parameter int NUMREQ  = 4,
  parameter int NUMELEM = NUMELEM_DEF,
  parameter int BITDATA = BITDATA_DEF,
  localparam int BITELEM = bitelem(NUMELEM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUMREQ-1:0]         req,
  input  logic [NUMREQ*BITDATA-1:0] req_din,
  output logic [NUMREQ-1:0]         gnt,
  input  logic                      pop_req,
  output logic                      pop_ok,
  output logic                      push,
  output logic [BITDATA-1:0]        pu_din,
  output logic                      pop,
  output logic [BITELEM:0]          cnt,
  output logic                      full,
  output logic                      empty
);

  localparam logic [BITELEM:0] FULL_CNT = (BITELEM + 1)'(NUMELEM);

  logic can_push;

  assign empty    = (cnt == '0);
  assign full     = (cnt == FULL_CNT);
  // Pop depends only on registered count, never on a same-cycle push.
  assign pop      = !rst && pop_req && !empty;
  assign pop_ok   = pop;
  assign can_push = !rst && (!full || pop);
  assign push     = |gnt;

  rr_arbiter #(.NUMREQ(NUMREQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (can_push),
    .gnt (gnt)
  );

  // One-hot AND-OR mux; zero when nothing is granted.
  always_comb begin
    pu_din = '0;
    for (int i = 0; i < NUMREQ; i++)
      if (gnt[i]) pu_din = pu_din | req_din[i*BITDATA +: BITDATA];
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else begin
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full && !pop));
      assert (!(pop && empty));
      assert ($onehot0(gnt));
    end
  end

endmodule

// File: tb/tb_buff_share_ctrl.sv
// Directed bench for buff_share_ctrl with a small FIFO model standing in for static_buff.
module tb_buff_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_din;
  logic [3:0]  gnt;
  logic        pop_req;
  logic        pop_ok;
  logic        push;
  logic [3:0]  pu_din;
  logic        pop;
  logic [2:0]  cnt;
  logic        full;
  logic        empty;

  int checks   = 0;
  int failures = 0;

  logic [3:0] fifo_q[$];

  buff_share_ctrl #(.NUMREQ(4), .NUMELEM(4), .BITDATA(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_din (req_din),
    .gnt     (gnt),
    .pop_req (pop_req),
    .pop_ok  (pop_ok),
    .push    (push),
    .pu_din  (pu_din),
    .pop     (pop),
    .cnt     (cnt),
    .full    (full),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  // Stand-in buffer: holds what the controller actually pushed.
  always @(posedge clk) begin
    if (rst) fifo_q.delete();
    else begin
      if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (push) fifo_q.push_back(pu_din);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] front();
    return (fifo_q.size() > 0) ? {28'd0, fifo_q[0]} : 32'hFFFF_FFFF;
  endfunction

  initial begin
    rst = 1'b1; req = 4'b1111; pop_req = 1'b1; req_din = 16'h4321;

    // Reset held two cycles with everything requesting
    for (int c = 0; c < 2; c++) begin
      step(); #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_push", push, 0);
      chk("rst_pop", pop, 0);
      chk("rst_pu_din", pu_din, 0);
    end
    rst = 1'b0; pop_req = 1'b0;
    #1;
    chk("post_rst_cnt", cnt, 0);
    chk("post_rst_empty", empty, 1);
    chk("post_rst_full", full, 0);

    // Round-robin fill 0,1,2,3
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_gnt%0d", k), gnt, 32'(1 << k));
      chk($sformatf("rr_din%0d", k), pu_din, k + 1);
      step(); #1;
    end
    chk("fill_cnt", cnt, 4);
    chk("fill_full", full, 1);
    chk("fill_gnt", gnt, 0);
    chk("fill_push", push, 0);
    chk("fill_pu_din", pu_din, 0);

    // Full with simultaneous pop: rr_ptr=0, only producer 2 requests
    req = 4'b0100; pop_req = 1'b1; #1;
    chk("fp_pop", pop, 1);
    chk("fp_push", push, 1);
    chk("fp_gnt", gnt, 4'b0100);
    chk("fp_din", pu_din, 3);
    chk("fp_oldest", front(), 1);
    step(); #1;
    chk("fp_cnt", cnt, 4);

    // Drain: expected order 2,3,4,3
    req = 4'b0000; #1;
    begin
      logic [3:0] exp_q [4];
      exp_q = '{4'h2, 4'h3, 4'h4, 4'h3};
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("drain_pop%0d", k), pop, 1);
        chk($sformatf("drain_data%0d", k), front(), exp_q[k]);
        step(); #1;
      end
    end
    chk("drain_cnt", cnt, 0);
    chk("drain_empty", empty, 1);

    // Empty guard: pop dropped, push of 0xA accepted (rr_ptr=3 wraps to 0)
    req = 4'b0001; req_din = 16'h432A; pop_req = 1'b1; #1;
    chk("eg_pop_ok", pop_ok, 0);
    chk("eg_push", push, 1);
    chk("eg_gnt", gnt, 4'b0001);
    step(); #1;
    chk("eg_cnt", cnt, 1);
    req = 4'b0000; #1;
    chk("eg_pop_ok2", pop_ok, 1);
    chk("eg_data", front(), 4'hA);
    step(); #1;
    chk("eg_cnt2", cnt, 0);

    // Fairness: req[0] held, req[1] joins at cycle 5, consumer draining
    req = 4'b0001; pop_req = 1'b1; #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("fair_g0_%0d", c), gnt, 4'b0001);
      step(); #1;
    end
    req = 4'b0011; #1;
    chk("fair_g1", gnt, 4'b0010);
    step(); #1;
    chk("fair_after", gnt, 4'b0001);
    step(); #1;
    chk("fair_cnt", cnt, 1);

    // Mid-operation reset: build cnt=3 with rr_ptr left at 2
    req = 4'b0010; pop_req = 1'b0; #1;
    step(); step(); #1;
    chk("mid_cnt3", cnt, 3);
    rst = 1'b1; req = 4'b1010; #1;
    chk("mid_rst_gnt", gnt, 0);
    step();
    rst = 1'b0; #1;
    chk("mid_cnt0", cnt, 0);
    chk("mid_empty", empty, 1);
    chk("mid_gnt", gnt, 4'b0010);
    chk("mid_din", pu_din, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
